spi_csr_bridge: RTL and testbench



---
 rtl/spi_csr_bridge.sv | 145 ++++++++++++++
 tb/tb_spi_csr_bridge.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_csr_bridge.sv
// SPI (mode 0) target that masters the 5-bit-address / 8-bit-data CSR bus.
// The SPI pins are oversampled with clk. Command and data bytes become single-cycle CSR writes or prefetched CSR reads.
module spi_csr_bridge #(
  parameter bit AUTO_INC = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [4:0] csr_a,
  output logic [7:0] csr_di,
  output logic       csr_we,
  input  logic [7:0] csr_do
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t      state, state_nxt;
  logic [1:0]  sck_s, cs_s, mosi_s;
  logic        sck_d;
  logic        sck_q, cs_q, mosi_q;
  logic        sck_rise, sck_fall;
  logic        armed;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_sr, tx_sr, rx_byte;
  logic        wr;
  logic        rd_pend;
  logic        hold_fall;

  // Strobes decoded from state and the synchronised pins
  logic        clear, shift_en, byte_end, cmd_done, data_done;

  assign sck_q    = sck_s[1];
  assign cs_q     = cs_s[1];
  assign mosi_q   = mosi_s[1];
  assign sck_rise = sck_q & ~sck_d;
  assign sck_fall = ~sck_q & sck_d;
  assign rx_byte  = {rx_sr[6:0], mosi_q};
  assign spi_miso = tx_sr[7];

  // cs_n resets to "selected" so that a frame already in progress is never armed before cs_n goes high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s  <= 2'b00;
      cs_s   <= 2'b00;
      mosi_s <= 2'b00;
      sck_d  <= 1'b0;
    end else begin
      sck_s  <= {sck_s[0], spi_sck};
      cs_s   <= {cs_s[0], spi_cs_n};
      mosi_s <= {mosi_s[0], spi_mosi};
      sck_d  <= sck_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!cs_q && armed) state_nxt = CMD;
      CMD:     if (cs_q) state_nxt = IDLE;
               else if (cmd_done) state_nxt = DATA;
      DATA:    if (cs_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: combinational blocks assign every output a default first, so no latches are inferred.
  always_comb begin
    clear     = 1'b0;
    shift_en  = 1'b0;
    byte_end  = 1'b0;
    cmd_done  = 1'b0;
    data_done = 1'b0;
    if (state == IDLE || cs_q) begin
      clear = 1'b1;
    end else begin
      shift_en  = sck_rise;
      byte_end  = sck_rise && (bit_cnt == 3'd7);
      cmd_done  = byte_end && (state == CMD);
      data_done = byte_end && (state == DATA);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments in this block override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed       <= 1'b0;
      bit_cnt     <= 3'd0;
      rx_sr       <= 8'h00;
      tx_sr       <= 8'h00;
      hold_fall   <= 1'b0;
      wr          <= 1'b0;
      rd_pend     <= 1'b0;
      csr_a       <= 5'd0;
      csr_di      <= 8'h00;
      csr_we      <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      spi_miso_oe <= ~cs_q;
      if (state == IDLE && cs_q) armed <= 1'b1;

      if (clear) begin
        bit_cnt   <= 3'd0;
        rx_sr     <= 8'h00;
        tx_sr     <= 8'h00;
        hold_fall <= 1'b0;
      end else begin
        if (shift_en) begin
          rx_sr   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
        end
        // The freshly loaded MSB must survive the fall right after a byte completes
        if (sck_fall) begin
          if (hold_fall) hold_fall <= 1'b0;
          else           tx_sr     <= {tx_sr[6:0], 1'b0};
        end
        if (byte_end) hold_fall <= 1'b1;
      end

      if (cmd_done) begin
        csr_a <= rx_byte[4:0];
        wr    <= rx_byte[7];
      end

      csr_we <= data_done && wr;
      if (data_done && wr) csr_di <= rx_byte;

      rd_pend <= (cmd_done && !rx_byte[7]) || (data_done && !wr);
      if (rd_pend) begin
        if (!clear) tx_sr <= csr_do;
        if (AUTO_INC) csr_a <= csr_a + 5'd1;
      end
      if (csr_we && AUTO_INC) csr_a <= csr_a + 5'd1;
    end
  end

endmodule

// File: tb/tb_spi_csr_bridge.sv
// Self-checking bench for spi_csr_bridge: a bit-banged SPI host and scoreboards for the expected CSR writes and MISO bytes.
module tb_spi_csr_bridge;

  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n0 = 1'b1;
  logic       cs_n1 = 1'b1;
  logic       sel = 1'b0;
  logic       miso0, miso1, oe0, oe1, we0, we1;
  logic [4:0] a0, a1;
  logic [7:0] di0, di1, do0, do1;
  logic       miso;

  int n_checks = 0;
  int n_fail   = 0;

  wr_t        wq0[$];
  wr_t        wq1[$];
  logic [7:0] rxq[$];

  always #5 clk = ~clk;

  assign do0  = {3'b000, a0} ^ 8'h5A;
  assign do1  = {3'b000, a1} ^ 8'h5A;
  assign miso = sel ? miso1 : miso0;

  spi_csr_bridge #(.AUTO_INC(1'b1)) dut0 (
    .clk(clk), .rst(rst), .spi_sck(sck), .spi_cs_n(cs_n0), .spi_mosi(mosi),
    .spi_miso(miso0), .spi_miso_oe(oe0), .csr_a(a0), .csr_di(di0),
    .csr_we(we0), .csr_do(do0)
  );

  spi_csr_bridge #(.AUTO_INC(1'b0)) dut1 (
    .clk(clk), .rst(rst), .spi_sck(sck), .spi_cs_n(cs_n1), .spi_mosi(mosi),
    .spi_miso(miso1), .spi_miso_oe(oe1), .csr_a(a1), .csr_di(di1),
    .csr_we(we1), .csr_do(do1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Write scoreboards: every csr_we pulse must match the oldest expected write
  always @(negedge clk) begin
    if (we0) begin
      if (wq0.size() == 0) check("we0_unexpected", 1, 0);
      else begin
        wr_t e;
        e = wq0.pop_front();
        check("we0_addr", a0, e.a);
        check("we0_data", di0, e.d);
      end
    end
    if (we1) begin
      if (wq1.size() == 0) check("we1_unexpected", 1, 0);
      else begin
        wr_t e;
        e = wq1.pop_front();
        check("we1_addr", a1, e.a);
        check("we1_data", di1, e.d);
      end
    end
  end

  task automatic set_cs(input logic v);
    if (sel) cs_n1 = v;
    else     cs_n0 = v;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      repeat (6) @(negedge clk);
      rx[i] = miso;
      sck = 1'b1;
      repeat (6) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic [7:0] exp_rx);
    logic [7:0] rx;
    rxq.push_back(exp_rx);
    spi_bits(b, 8, rx);
    check("miso_byte", rx, rxq.pop_front());
  endtask

  task automatic frame_begin(input logic s);
    sel = s;
    set_cs(1'b0);
    repeat (6) @(negedge clk);
    check("oe_active", sel ? oe1 : oe0, 1'b1);
  endtask

  task automatic frame_end();
    logic [7:0] dummy;
    dummy = 8'h00;
    repeat (6) @(negedge clk);
    set_cs(1'b1);
    repeat (10) @(negedge clk);
    check("oe_idle", sel ? oe1 : oe0, 1'b0);
    mosi = dummy[0];
  endtask

  task automatic exp_wr(input logic s, input logic [4:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    if (s) wq1.push_back(e);
    else   wq0.push_back(e);
  endtask

  initial begin
    logic [7:0] rx;

    repeat (4) @(negedge clk);
    check("rst_csr_a", a0, 5'd0);
    check("rst_csr_di", di0, 8'h00);
    check("rst_csr_we", we0, 1'b0);
    check("rst_miso", miso0, 1'b0);
    check("rst_oe", oe0, 1'b0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // 1. single write
    frame_begin(1'b0);
    exp_wr(1'b0, 5'h03, 8'hA5);
    spi_byte(8'h83, 8'h00);
    spi_byte(8'hA5, 8'h00);
    frame_end();

    // 2. burst write wrapping 0x1F -> 0x00
    frame_begin(1'b0);
    exp_wr(1'b0, 5'h1F, 8'h11);
    exp_wr(1'b0, 5'h00, 8'h22);
    exp_wr(1'b0, 5'h01, 8'h33);
    spi_byte(8'h9F, 8'h00);
    spi_byte(8'h11, 8'h00);
    spi_byte(8'h22, 8'h00);
    spi_byte(8'h33, 8'h00);
    frame_end();

    // 3. burst read, slave returns addr ^ 0x5A
    frame_begin(1'b0);
    spi_byte(8'h02, 8'h00);
    spi_byte(8'hFF, 8'h58);
    spi_byte(8'hC3, 8'h59);
    frame_end();

    // 4. abort mid-byte, then a clean write
    frame_begin(1'b0);
    spi_byte(8'h85, 8'h00);
    spi_bits(8'hFF, 5, rx);
    frame_end();
    check("abort_csr_a", a0, 5'h05);
    frame_begin(1'b0);
    exp_wr(1'b0, 5'h05, 8'h3C);
    spi_byte(8'h85, 8'h00);
    spi_byte(8'h3C, 8'h00);
    frame_end();

    // 5. fixed address on the AUTO_INC=0 instance
    frame_begin(1'b1);
    exp_wr(1'b1, 5'h04, 8'h01);
    exp_wr(1'b1, 5'h04, 8'h02);
    spi_byte(8'h84, 8'h00);
    spi_byte(8'h01, 8'h00);
    spi_byte(8'h02, 8'h00);
    frame_end();
    check("noinc_csr_a", a1, 5'h04);

    // 6. reset in the middle of a write frame
    frame_begin(1'b0);
    spi_byte(8'h81, 8'h00);
    spi_bits(8'hFF, 3, rx);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_csr_a", a0, 5'd0);
    check("midrst_csr_di", di0, 8'h00);
    check("midrst_csr_we", we0, 1'b0);
    check("midrst_miso", miso0, 1'b0);
    check("midrst_oe", oe0, 1'b0);
    rst = 1'b0;
    spi_bits(8'hFF, 5, rx);
    spi_byte(8'hA7, 8'h00);
    check("postrst_csr_a", a0, 5'd0);
    frame_end();
    frame_begin(1'b0);
    exp_wr(1'b0, 5'h06, 8'h77);
    spi_byte(8'h86, 8'h00);
    spi_byte(8'h77, 8'h00);
    frame_end();

    repeat (20) @(negedge clk);
    check("wq0_drained", wq0.size(), 0);
    check("wq1_drained", wq1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
